// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM types and constants (length-tracker FSM states, block size, length-block packing)
package gcm_pkg;
   localparam int GCM_BLK_BYTES = 16;
   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_EMIT, ST_ERR} len_state_e;
   function automatic logic [127:0] gcm_pack_len(input logic [63:0] aad_bits, input logic [63:0] ct_bits);
      return {aad_bits, ct_bits};
   endfunction
endpackage

// File: rtl/gcm_len_tracker.sv
// gcm_len_tracker: counts AAD/CT bytes of a GCM message and emits the final len(A)||len(C) block
// Ports: clk, rst (async, active-high); start/finish message pulses; seg_valid, seg_is_aad, seg_nbytes
// segment stream; len_valid/len_ready/len_block length-block handshake; busy (ACC or EMIT); err (sticky).
import gcm_pkg::*;
module gcm_len_tracker #(
   parameter int CNT_W = 36,
   parameter logic [63:0] CT_MAX_BYTES = 64'hF_FFFF_FFF0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         seg_valid,
   input  logic         seg_is_aad,
   input  logic [4:0]   seg_nbytes,
   input  logic         finish,
   output logic         len_valid,
   input  logic         len_ready,
   output logic [127:0] len_block,
   output logic         busy,
   output logic         err
);
   len_state_e state;
   logic [CNT_W-1:0] aad_cnt, ct_cnt, aad_nxt, ct_nxt;
   logic [CNT_W:0] aad_sum, ct_sum;
   logic seen_ct, bad_len, ct_ovf, seg_err;
   // Sums carry one extra bit so counter-width overflow is visible before anything is committed.
   always_comb begin
      aad_sum = {1'b0, aad_cnt} + (CNT_W+1)'(seg_nbytes);
      ct_sum  = {1'b0, ct_cnt} + (CNT_W+1)'(seg_nbytes);
      bad_len = seg_nbytes == 5'd0 || seg_nbytes > 5'(GCM_BLK_BYTES);
      ct_ovf  = ct_sum[CNT_W] || 64'(ct_sum) > CT_MAX_BYTES;
      seg_err = seg_valid && (bad_len || (seg_is_aad ? (seen_ct || aad_sum[CNT_W]) : ct_ovf));
      aad_nxt = (seg_valid && seg_is_aad) ? aad_sum[CNT_W-1:0] : aad_cnt;
      ct_nxt  = (seg_valid && !seg_is_aad) ? ct_sum[CNT_W-1:0] : ct_cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         aad_cnt   <= '0;
         ct_cnt    <= '0;
         seen_ct   <= 1'b0;
         len_valid <= 1'b0;
         len_block <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else if (start) begin
         // start restarts the message from every state and overrides segments, finish and transfers
         state     <= ST_ACC;
         aad_cnt   <= '0;
         ct_cnt    <= '0;
         seen_ct   <= 1'b0;
         len_valid <= 1'b0;
         busy      <= 1'b1;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (seg_err) begin
                  state <= ST_ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  aad_cnt <= aad_nxt;
                  ct_cnt  <= ct_nxt;
                  seen_ct <= seen_ct || (seg_valid && !seg_is_aad);
                  if (finish) begin
                     // pack from the post-add counts so a segment arriving with finish is included
                     state     <= ST_EMIT;
                     len_valid <= 1'b1;
                     len_block <= gcm_pack_len(64'(aad_nxt) << 3, 64'(ct_nxt) << 3);
                  end
               end
            end
            ST_EMIT: begin
               if (len_ready) begin
                  state     <= ST_IDLE;
                  len_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/gcm_len_tracker.md
GCM_LEN_TRACKER -- requirements
Module: gcm_len_tracker

Interface
REQ-001 Parameter CNT_W, default 36: byte-counter width per field; legal range 8..61.
REQ-002 Parameter CT_MAX_BYTES, default 36'hF_FFFF_FFF0 (2^36-16): largest legal CT byte total; AAD limit is 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse: clear both counters and begin a new message.
REQ-006 seg_valid  input  1  a data segment is presented this cycle.
REQ-007 seg_is_aad  input  1  segment class: 1 = AAD, 0 = ciphertext.
REQ-008 seg_nbytes  input  5  valid bytes in the segment, 1..16.
REQ-009 finish  input  1  one-cycle pulse: no further segments; emit the length block.
REQ-010 len_valid  output  1  length block available.
REQ-011 len_ready  input  1  consumer accepts the length block.
REQ-012 len_block  output  128  {len(AAD) in bits, len(CT) in bits}, each 64-bit big-endian field.
REQ-013 busy  output  1  high in ACC and EMIT.
REQ-014 err  output  1  sticky error flag; cleared only by start or rst.

Function
REQ-015 FSM states: IDLE, ACC, EMIT, ERR.
REQ-016 IDLE: start -> ACC with both counters cleared; seg_valid and finish are ignored.
REQ-017 ACC, seg_valid: add seg_nbytes to the AAD counter (seg_is_aad=1) or the CT counter (0); the update is visible next cycle.
REQ-018 ACC ordering: an AAD segment after any CT segment in the same message -> ERR, err=1; counters are not updated.
REQ-019 ACC, seg_nbytes of 0 or >16: -> ERR, err=1.
REQ-020 Overflow: an AAD sum exceeding 2^CNT_W-1, or a CT sum exceeding CT_MAX_BYTES -> ERR, err=1; the counter holds its pre-add value.
REQ-021 ACC, finish -> EMIT. If seg_valid is also high that cycle, the segment is counted first and included in len_block.
REQ-022 ACC, start: counters clear and the state stays ACC (restart); start has priority over seg_valid and finish.
REQ-023 EMIT: len_valid=1; len_block = {zero-extend(aad_bytes<<3) to 64, zero-extend(ct_bytes<<3) to 64}; the value is stable while len_ready=0.
REQ-024 EMIT, len_ready=1: transfer completes -> IDLE, len_valid=0 next cycle. Segments and finish in EMIT are ignored; start in EMIT aborts to ACC with cleared counters and no transfer.
REQ-025 ERR: len_valid=0, busy=0; only start (-> ACC, err=0) or rst leaves ERR.
REQ-026 len_block is registered, not combinational from the counters; latency from finish to len_valid is exactly 1 cycle.
REQ-027 Zero-length message (start then finish, no segments): len_block = 128'h0, len_valid asserted.

Reset
REQ-028 rst asserted: state=IDLE, both counters=0, len_valid=0, len_block=0, busy=0, err=0; takes effect immediately, independent of clk.
REQ-029 rst mid-message or mid-EMIT discards all accumulated state; no len_block transfer completes.

Structure
REQ-030 The FSM state encoding and the 16-byte block-size constant live in the shared GCM package (gcm_pkg).
REQ-031 No sub-module; the combinational packing reuses the existing length-block packing logic inline, with no new packing module.

Verification
REQ-032 start; AAD 16,16,4; CT 16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,16,9 (329 bytes); finish -> len_block = {64'd288, 64'd2632}, len_valid one cycle after finish.
REQ-033 start; finish -> len_block = 128'h0; hold len_ready=0 for 5 cycles -> len_valid and len_block stable; len_ready=1 -> IDLE.
REQ-034 start; CT 16; AAD 16 -> err=1, state ERR, len_valid never asserted; start -> err=0, counters 0.
REQ-035 CNT_W=8: start; AAD 16 x15 (240 bytes); AAD 16 -> err=1, AAD counter holds 240.
REQ-036 start; CT 7 with finish in the same cycle -> len_block = {64'd0, 64'd56}.
REQ-037 start; AAD 16; assert rst asynchronously between edges -> all outputs 0 before the next clk edge; a later finish is ignored in IDLE.
